acq_addr_sched: RTL

//  Acquisition address scheduler for the echo-acquisition datapath.

---
 rtl/acq_addr_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/acq_addr_sched.sv
// Acquisition address scheduler: steps addrout from 1 to a programmed last
// address, holding a fixed settle time then a programmable acq_en window at
// each address, and repeats the pass a programmed number of times.
module acq_addr_sched #(
   parameter int AW     = 4,
   parameter int DW     = 16,
   parameter int RW     = 8,
   parameter int SETTLE = 4
) (
   input  logic          clk_sys,
   input  logic          rst_n,
   input  logic          load,
   input  logic [AW-1:0] datain,
   input  logic [DW-1:0] dwell_in,
   input  logic [RW-1:0] rep_in,
   input  logic          start,
   input  logic          abort,
   output logic [AW-1:0] addrout,
   output logic          acq_en,
   output logic          busy,
   output logic          scan_done,
   output logic          done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_ACQ,
      ST_DONE
   } state_t;

   // One counter serves both the settle and the dwell phase, so it is sized
   // for the dwell window; the settle terminal count is a constant.
   localparam logic [DW-1:0] SETTLE_LAST = DW'(SETTLE - 1);
   localparam logic [AW-1:0] ADDR_ONE    = AW'(1);
   localparam logic [DW-1:0] DWELL_ONE   = DW'(1);
   localparam logic [RW-1:0] REP_ONE     = RW'(1);

   state_t        state_reg, state_next;
   logic [AW-1:0] last_reg, last_next;
   logic [DW-1:0] dwell_reg, dwell_next;
   logic [RW-1:0] rep_reg, rep_next;
   logic [AW-1:0] addr_reg, addr_next;
   logic [RW-1:0] pass_reg, pass_next;
   logic [DW-1:0] cnt_reg, cnt_next;
   logic          acq_en_reg, acq_en_next;
   logic          busy_reg, busy_next;
   logic          scan_done_reg, scan_done_next;
   logic          done_reg, done_next;
   logic [DW-1:0] dwell_last;

   assign dwell_last = dwell_reg - DWELL_ONE;

   // Next-state, counter, config-capture and output look-ahead logic.
   always_comb begin
      state_next     = state_reg;
      last_next      = last_reg;
      dwell_next     = dwell_reg;
      rep_next       = rep_reg;
      addr_next      = addr_reg;
      pass_next      = pass_reg;
      cnt_next       = cnt_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start && !abort) begin
               // start wins over a simultaneous load: the old config is used
               state_next = ST_SETTLE;
               addr_next  = ADDR_ONE;
               pass_next  = REP_ONE;
               cnt_next   = '0;
            end else if (load) begin
               last_next  = (datain   == '0) ? ADDR_ONE  : datain;
               dwell_next = (dwell_in == '0) ? DWELL_ONE : dwell_in;
               rep_next   = (rep_in   == '0) ? REP_ONE   : rep_in;
            end
         end
         ST_SETTLE: begin
            if (cnt_reg == SETTLE_LAST) begin
               state_next = ST_ACQ;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + DWELL_ONE;
            end
         end
         ST_ACQ: begin
            if (cnt_reg == dwell_last) begin
               cnt_next = '0;
               if (addr_reg < last_reg) begin
                  addr_next  = addr_reg + ADDR_ONE;
                  state_next = ST_SETTLE;
               end else if (pass_reg < rep_reg) begin
                  addr_next  = ADDR_ONE;
                  pass_next  = pass_reg + REP_ONE;
                  state_next = ST_SETTLE;
               end else begin
                  addr_next  = ADDR_ONE;
                  state_next = ST_DONE;
               end
            end else begin
               cnt_next = cnt_reg + DWELL_ONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
            addr_next  = ADDR_ONE;
            cnt_next   = '0;
         end
      endcase

      // abort overrides every other transition outside IDLE
      if (abort && (state_reg != ST_IDLE)) begin
         state_next = ST_IDLE;
         addr_next  = ADDR_ONE;
         cnt_next   = '0;
      end

      // Outputs are registered from the next-state values so they line up
      // with the state they describe; scan_done marks the final ACQ cycle of
      // the last address in every pass.
      acq_en_next    = (state_next == ST_ACQ);
      busy_next      = (state_next != ST_IDLE);
      done_next      = (state_next == ST_DONE);
      scan_done_next = (state_next == ST_ACQ) && (cnt_next == dwell_last) &&
                       (addr_next == last_reg);
   end

   // State, config and output registers with synchronous active-low reset.
   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         last_reg      <= ADDR_ONE;
         dwell_reg     <= DWELL_ONE;
         rep_reg       <= REP_ONE;
         addr_reg      <= ADDR_ONE;
         pass_reg      <= '0;
         cnt_reg       <= '0;
         acq_en_reg    <= 1'b0;
         busy_reg      <= 1'b0;
         scan_done_reg <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         last_reg      <= last_next;
         dwell_reg     <= dwell_next;
         rep_reg       <= rep_next;
         addr_reg      <= addr_next;
         pass_reg      <= pass_next;
         cnt_reg       <= cnt_next;
         acq_en_reg    <= acq_en_next;
         busy_reg      <= busy_next;
         scan_done_reg <= scan_done_next;
         done_reg      <= done_next;
      end
   end

   assign addrout   = addr_reg;
   assign acq_en    = acq_en_reg;
   assign busy      = busy_reg;
   assign scan_done = scan_done_reg;
   assign done      = done_reg;

endmodule
